cl_axil_regfile: RTL and testbench

- Parametrised AXI-Lite slave register bank on the PCIe OCL path (AppPF BAR0), placed after the OCL register slice in the CL top.
- Provides NUM_REGS read/write control registers with byte strobes, NUM_STATUS read-only status words, and a virtual-LED output mirror.
- Returns AXI error responses for writes to read-only words and for unmapped addresses.
- Accepts AW and W in either order.

---
 rtl/cl_axil_regfile.sv | 230 +++++++++++++++++++++++
 tb/tb_cl_axil_regfile.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_axil_regfile.sv
// AXI-Lite register bank for the OCL path: NUM_REGS RW words, NUM_STATUS RO status words, vLED mirror.
// Define CL_AXIL_REGFILE_WR_PULSE_EN to add wr_pulse_o, a one-cycle strobe per committed RW register.
module cl_axil_regfile #(
  parameter int          ADDR_W       = 32,
  parameter int          NUM_REGS     = 8,
  parameter int          NUM_STATUS   = 4,
  parameter int          VLED_REG     = 0,
  parameter logic [31:0] UNIMPL_VALUE = 32'hDEAD_BEEF,
  localparam int         STAT_N       = (NUM_STATUS > 0) ? NUM_STATUS : 1
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main_n,
  input  logic                     s_awvalid,
  input  logic [ADDR_W-1:0]        s_awaddr,
  output logic                     s_awready,
  input  logic                     s_wvalid,
  input  logic [31:0]              s_wdata,
  input  logic [3:0]               s_wstrb,
  output logic                     s_wready,
  output logic                     s_bvalid,
  output logic [1:0]               s_bresp,
  input  logic                     s_bready,
  input  logic                     s_arvalid,
  input  logic [ADDR_W-1:0]        s_araddr,
  output logic                     s_arready,
  output logic                     s_rvalid,
  output logic [31:0]              s_rdata,
  output logic [1:0]               s_rresp,
  input  logic                     s_rready,
  output logic [NUM_REGS*32-1:0]   reg_q_o,
  input  logic [STAT_N*32-1:0]     status_i,
`ifdef CL_AXIL_REGFILE_WR_PULSE_EN
  output logic [NUM_REGS-1:0]      wr_pulse_o,
`endif
  output logic [15:0]              vled_o
);

  localparam int WORD_W     = ADDR_W - 2;
  localparam int REG_IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STAT_IDX_W = (STAT_N > 1) ? $clog2(STAT_N) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {TGT_RW, TGT_RO, TGT_NONE} tgt_e;

  typedef struct packed {
    tgt_e                  tgt;
    logic [REG_IDX_W-1:0]  reg_idx;
    logic [STAT_IDX_W-1:0] stat_idx;
  } decode_t;

  // Word-granular decode: RW bank first, status words right after it, everything else unmapped.
  function automatic decode_t decode(input logic [WORD_W-1:0] word);
    logic [63:0] w;
    decode_t     d;
    w          = 64'(word);
    d.tgt      = TGT_NONE;
    d.reg_idx  = word[REG_IDX_W-1:0];
    d.stat_idx = '0;
    if (w < 64'(NUM_REGS)) begin
      d.tgt = TGT_RW;
    end else if (w < 64'(NUM_REGS) + 64'(NUM_STATUS)) begin
      d.tgt      = TGT_RO;
      d.stat_idx = STAT_IDX_W'(w - 64'(NUM_REGS));
    end
    return d;
  endfunction

  logic              aw_held_q, aw_held_d;
  logic [WORD_W-1:0] aw_word_q, aw_word_d;
  logic              w_held_q, w_held_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];
  logic [15:0]       vled_q, vled_d;
  logic [31:0]       status_w [STAT_N];

  logic    commit;
  decode_t wr_dec;
  decode_t rd_dec;
  logic    unused_addr_bits;

  assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

  for (genvar i = 0; i < STAT_N; i++) begin : g_status
    assign status_w[i] = status_i[32*i +: 32];
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_q_o[32*i +: 32] = regs_q[i];
  end

  assign s_awready = !aw_held_q;
  assign s_wready  = !w_held_q;
  assign s_arready = !rvalid_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign vled_o    = vled_q;

  assign wr_dec = decode(aw_word_q);
  assign rd_dec = decode(s_araddr[ADDR_W-1:2]);
  // A held pair waits here while a previous B response is still outstanding.
  assign commit = aw_held_q && w_held_q && !bvalid_q;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
    aw_held_d = aw_held_q;
    aw_word_d = aw_word_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;
    vled_d    = regs_q[VLED_REG][15:0];

    if (s_awvalid && s_awready) begin
      aw_held_d = 1'b1;
      aw_word_d = s_awaddr[ADDR_W-1:2];
    end
    if (s_wvalid && s_wready) begin
      w_held_d = 1'b1;
      w_data_d = s_wdata;
      w_strb_d = s_wstrb;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      unique case (wr_dec.tgt)
        TGT_RW: begin
          bresp_d = RESP_OKAY;
          for (int k = 0; k < 4; k++) begin
            if (w_strb_q[k]) regs_d[wr_dec.reg_idx][8*k +: 8] = w_data_q[8*k +: 8];
          end
        end
        TGT_RO:  bresp_d = RESP_SLVERR;
        default: bresp_d = RESP_DECERR;
      endcase
    end else if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end

    // Reads see regs_q, so a read racing a commit returns the pre-write value.
    if (s_arvalid && s_arready) begin
      rvalid_d = 1'b1;
      unique case (rd_dec.tgt)
        TGT_RW: begin
          rdata_d = regs_q[rd_dec.reg_idx];
          rresp_d = RESP_OKAY;
        end
        TGT_RO: begin
          rdata_d = status_w[rd_dec.stat_idx];
          rresp_d = RESP_OKAY;
        end
        default: begin
          rdata_d = UNIMPL_VALUE;
          rresp_d = RESP_DECERR;
        end
      endcase
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
    end
  end

  // NOTE: the register bank is a flop array with a defined power-on value, not a RAM, so it is reset.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      aw_held_q <= 1'b0;
      aw_word_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      regs_q    <= '{default: '0};
      vled_q    <= '0;
    end else begin
      // NOTE: <= makes every flop sample the pre-edge value of its _d, independent of statement order.
      aw_held_q <= aw_held_d;
      aw_word_q <= aw_word_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
      vled_q    <= vled_d;
    end
  end

`ifdef CL_AXIL_REGFILE_WR_PULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  always_comb begin
    wr_pulse_d = '0;
    if (commit && (wr_dec.tgt == TGT_RW) && (|w_strb_q)) wr_pulse_d[wr_dec.reg_idx] = 1'b1;
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) wr_pulse_q <= '0;
    else             wr_pulse_q <= wr_pulse_d;
  end

  assign wr_pulse_o = wr_pulse_q;
`endif

endmodule

// File: tb/tb_cl_axil_regfile.sv
// Directed bench for cl_axil_regfile (default parameters); inputs driven on the falling edge,
// outputs sampled on the falling edge.
module tb_cl_axil_regfile;
  localparam int NUM_REGS   = 8;
  localparam int NUM_STATUS = 4;
  localparam int BUDGET     = 40;

  logic                       clk_main_a0 = 1'b0;
  logic                       rst_main_n  = 1'b1;
  logic                       s_awvalid = 1'b0;
  logic [31:0]                s_awaddr  = '0;
  logic                       s_awready;
  logic                       s_wvalid  = 1'b0;
  logic [31:0]                s_wdata   = '0;
  logic [3:0]                 s_wstrb   = '0;
  logic                       s_wready;
  logic                       s_bvalid;
  logic [1:0]                 s_bresp;
  logic                       s_bready  = 1'b0;
  logic                       s_arvalid = 1'b0;
  logic [31:0]                s_araddr  = '0;
  logic                       s_arready;
  logic                       s_rvalid;
  logic [31:0]                s_rdata;
  logic [1:0]                 s_rresp;
  logic                       s_rready  = 1'b0;
  logic [NUM_REGS*32-1:0]     reg_q_o;
  logic [NUM_STATUS*32-1:0]   status_i  = '0;
  logic [15:0]                vled_o;
`ifdef CL_AXIL_REGFILE_WR_PULSE_EN
  logic [NUM_REGS-1:0]        wr_pulse_o;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  cl_axil_regfile dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .s_awvalid   (s_awvalid),
    .s_awaddr    (s_awaddr),
    .s_awready   (s_awready),
    .s_wvalid    (s_wvalid),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_wready    (s_wready),
    .s_bvalid    (s_bvalid),
    .s_bresp     (s_bresp),
    .s_bready    (s_bready),
    .s_arvalid   (s_arvalid),
    .s_araddr    (s_araddr),
    .s_arready   (s_arready),
    .s_rvalid    (s_rvalid),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_rready    (s_rready),
    .reg_q_o     (reg_q_o),
    .status_i    (status_i),
`ifdef CL_AXIL_REGFILE_WR_PULSE_EN
    .wr_pulse_o  (wr_pulse_o),
`endif
    .vled_o      (vled_o)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue AW and W together; each drops as soon as its own handshake is seen.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int   n = 0;
    logic aw_hs, w_hs;
    s_awvalid = 1'b1; s_awaddr = addr;
    s_wvalid  = 1'b1; s_wdata  = data; s_wstrb = strb;
    while ((s_awvalid || s_wvalid) && n < BUDGET) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(negedge clk_main_a0);
      n++;
      if (aw_hs) s_awvalid = 1'b0;
      if (w_hs)  s_wvalid  = 1'b0;
    end
    check("write_handshake_timeout", 64'(n >= BUDGET), 64'd0);
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp);
    int n = 0;
    s_bready = 1'b1;
    while (!s_bvalid && n < BUDGET) begin
      @(negedge clk_main_a0);
      n++;
    end
    check("b_timeout", 64'(n >= BUDGET), 64'd0);
    resp = s_bresp;
    @(negedge clk_main_a0);
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    s_arvalid = 1'b1; s_araddr = addr;
    while (!s_arready && n < BUDGET) begin
      @(negedge clk_main_a0);
      n++;
    end
    @(negedge clk_main_a0);
    s_arvalid = 1'b0;
    while (!s_rvalid && n < BUDGET) begin
      @(negedge clk_main_a0);
      n++;
    end
    check("read_timeout", 64'(n >= BUDGET), 64'd0);
    data = s_rdata;
    resp = s_rresp;
    s_rready = 1'b1;
    @(negedge clk_main_a0);
    s_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;
    status_i = {32'hCAFE_0003, 32'h5555_AAAA, 32'h0BAD_F00D, 32'h1234_5678};

    // Reset state
    #1 rst_main_n = 1'b0;
    repeat (3) @(negedge clk_main_a0);
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    check("rst_awready", 64'(s_awready), 64'd1);
    check("rst_wready",  64'(s_wready),  64'd1);
    check("rst_arready", 64'(s_arready), 64'd1);
    check("rst_bvalid",  64'(s_bvalid),  64'd0);
    check("rst_rvalid",  64'(s_rvalid),  64'd0);
    check("rst_rdata",   64'(s_rdata),   64'd0);
    check("rst_resp",    64'({s_bresp, s_rresp}), 64'd0);
    check("rst_vled",    64'(vled_o),    64'd0);
    check("rst_regs_or", 64'(|reg_q_o),  64'd0);

    // Basic reads: RW register and status word 0
    do_read(32'h00, rd, rr);
    check("rd00_data", 64'(rd), 64'h0);
    check("rd00_resp", 64'(rr), 64'd0);
    do_read(32'h20, rd, rr);
    check("rd20_data", 64'(rd), 64'h1234_5678);
    check("rd20_resp", 64'(rr), 64'd0);

    // W two cycles ahead of AW
    s_wvalid = 1'b1; s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'hF;
    @(negedge clk_main_a0);
    s_wvalid = 1'b0;
    check("w_first_wready_low", 64'(s_wready), 64'd0);
    @(negedge clk_main_a0);
    @(negedge clk_main_a0);
    check("w_only_no_b", 64'(s_bvalid), 64'd0);
    s_awvalid = 1'b1; s_awaddr = 32'h04;
    @(negedge clk_main_a0);
    s_awvalid = 1'b0;
    check("aw_edge_no_b_yet", 64'(s_bvalid), 64'd0);
    check("aw_edge_no_update", 64'(reg_q_o[63:32]), 64'h0);
    @(negedge clk_main_a0);
    check("commit_bvalid", 64'(s_bvalid), 64'd1);
    check("commit_reg1", 64'(reg_q_o[63:32]), 64'hA5A5_A5A5);
    get_b(br);
    check("w_first_bresp", 64'(br), 64'd0);
    do_read(32'h04, rd, rr);
    check("rd04_data", 64'(rd), 64'hA5A5_A5A5);

    // Byte strobes
    do_write(32'h00, 32'hFFFF_FFFF, 4'h5);
    get_b(br);
    check("strb5_bresp", 64'(br), 64'd0);
    do_read(32'h00, rd, rr);
    check("strb5_data", 64'(rd), 64'h00FF_00FF);
    do_write(32'h04, 32'h1234_5678, 4'hA);
    get_b(br);
    do_read(32'h07, rd, rr);
    check("strbA_low_bits_ignored", 64'(rd), 64'h12A5_56A5);

    // RO and unmapped targets
    do_write(32'h20, 32'hFFFF_0000, 4'hF);
    get_b(br);
    check("ro_bresp", 64'(br), 64'd2);
    do_read(32'h20, rd, rr);
    check("ro_unchanged", 64'(rd), 64'h1234_5678);
    check("ro_regs_lo", reg_q_o[63:0], 64'h12A5_56A5_00FF_00FF);
    check("ro_regs_hi", 64'(|reg_q_o[255:64]), 64'd0);
    do_write(32'h100, 32'h0000_0001, 4'hF);
    get_b(br);
    check("unmapped_bresp", 64'(br), 64'd3);
    do_read(32'h100, rd, rr);
    check("unmapped_rdata", 64'(rd), 64'hDEAD_BEEF);
    check("unmapped_rresp", 64'(rr), 64'd3);

    // Decode boundaries
    do_read(32'h1C, rd, rr);
    check("last_rw_resp", 64'({rd, 30'd0, rr}), 64'd0);
    do_read(32'h2C, rd, rr);
    check("last_status", 64'({rd, 30'd0, rr}), {32'hCAFE_0003, 32'd0});
    do_read(32'h30, rd, rr);
    check("first_unmapped", 64'({rd, 30'd0, rr}), {32'hDEAD_BEEF, 32'd3});

    // Second write captured under B backpressure; responses return in order
    do_write(32'h24, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h0C, 32'h2222_2222, 4'hF);
    repeat (3) @(negedge clk_main_a0);
    check("bp_b_pending", 64'(s_bvalid), 64'd1);
    check("bp_aw_held", 64'(s_awready), 64'd0);
    check("bp_no_commit", 64'(reg_q_o[127:96]), 64'h0);
    get_b(br);
    check("bp_first_resp", 64'(br), 64'd2);
    check("bp_still_no_commit", 64'(reg_q_o[127:96]), 64'h0);
    get_b(br);
    check("bp_second_resp", 64'(br), 64'd0);
    check("bp_commit", 64'(reg_q_o[127:96]), 64'h2222_2222);

    // Read at the commit edge of the same register sees the old value
    do_write(32'h10, 32'h5A5A_5A5A, 4'hF);
    s_arvalid = 1'b1; s_araddr = 32'h10;
    @(negedge clk_main_a0);
    s_arvalid = 1'b0;
    check("race_bvalid", 64'(s_bvalid), 64'd1);
    check("race_rvalid", 64'(s_rvalid), 64'd1);
    check("race_old_value", 64'(s_rdata), 64'h0);
    check("race_reg4", 64'(reg_q_o[159:128]), 64'h5A5A_5A5A);
    s_rready = 1'b1;
    @(negedge clk_main_a0);
    s_rready = 1'b0;
    check("r_hs_clears", 64'({s_rvalid, s_rdata}), 64'd0);
    get_b(br);
    do_read(32'h10, rd, rr);
    check("race_new_value", 64'(rd), 64'h5A5A_5A5A);

    // vLED follows reg0 one cycle after the commit edge
    do_write(32'h00, 32'h0000_00F0, 4'hF);
    check("vled_before", 64'(vled_o), 64'h00FF);
    @(negedge clk_main_a0);
    check("vled_commit_reg0", 64'(reg_q_o[31:0]), 64'h0000_00F0);
    check("vled_commit_edge", 64'(vled_o), 64'h00FF);
`ifdef CL_AXIL_REGFILE_WR_PULSE_EN
    check("pulse_high", 64'(wr_pulse_o), 64'h01);
`endif
    @(negedge clk_main_a0);
    check("vled_after", 64'(vled_o), 64'h00F0);
`ifdef CL_AXIL_REGFILE_WR_PULSE_EN
    check("pulse_one_cycle", 64'(wr_pulse_o), 64'h00);
`endif
    get_b(br);
    check("vled_bresp", 64'(br), 64'd0);

    // Reset in the middle of a half-captured write
    s_wvalid = 1'b1; s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'hF;
    @(negedge clk_main_a0);
    s_wvalid = 1'b0;
    check("mid_w_held", 64'(s_wready), 64'd0);
    #2 rst_main_n = 1'b0;
    #1;
    check("mid_rst_wready", 64'(s_wready), 64'd1);
    check("mid_rst_regs", 64'(|reg_q_o), 64'd0);
    check("mid_rst_vled", 64'(vled_o), 64'd0);
    @(negedge clk_main_a0);
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    do_write(32'h14, 32'h0000_0077, 4'hF);
    get_b(br);
    do_read(32'h14, rd, rr);
    check("post_rst_rw", 64'({rd, 30'd0, rr}), {32'h77, 32'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
